bcd_to_bin_seq: RTL

// Sequential BCD-to-binary converter; the inverse of the binary-to-BCD display path.

---
 rtl/bcd_to_bin_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: iterative reverse double-dabble converter from packed BCD to
// unsigned binary, one bit per clock, behind a start/busy/done handshake.
// Invalid digits (A-F) bypass the iteration and report err with a zero result.
module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int TOT_W = BCD_W + BIN_W;
    localparam int CW    = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST_IT = CW'(BIN_W - 1);

    // The result register must hold the largest DIGITS-digit decimal value.
    if ((2 ** BIN_W) < (10 ** DIGITS)) begin : g_width_check
        $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [BCD_W-1:0]  bcd_sr;
    logic [BIN_W-1:0]  bin_sr;
    logic [CW-1:0]     it_cnt;
    logic              err_pend;
    logic              in_bad;

    // One reverse double-dabble iteration: shift the whole {bcd, bin} pair right,
    // then pull every BCD digit that landed at >= 8 back down by 3.
    function automatic logic [TOT_W-1:0] rev_dabble(input logic [TOT_W-1:0] v);
        logic [TOT_W-1:0] s;
        logic [3:0]       d;
        s = v >> 1;
        for (int k = 0; k < DIGITS; k++) begin
            d = s[BIN_W + 4*k +: 4];
            if (d >= 4'd8) begin
                s[BIN_W + 4*k +: 4] = d - 4'd3;
            end
        end
        return s;
    endfunction

    // True when any packed digit is outside 0..9.
    function automatic logic any_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign in_bad = any_bad_digit(bcd_in);
    assign busy   = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: invalid operands skip straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = in_bad ? DONE : CONV;
                end
            end
            CONV: begin
                if (it_cnt == LAST_IT) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result/err publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_sr   <= '0;
            bin_sr   <= '0;
            it_cnt   <= '0;
            err_pend <= 1'b0;
            bin_out  <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_sr   <= bcd_in;
                        bin_sr   <= '0;
                        it_cnt   <= '0;
                        err_pend <= in_bad;
                    end
                end
                CONV: begin
                    {bcd_sr, bin_sr} <= rev_dabble({bcd_sr, bin_sr});
                    it_cnt           <= it_cnt + CW'(1);
                end
                DONE: begin
                    bin_out <= err_pend ? '0 : bin_sr;
                    err     <= err_pend;
                end
                default: ;
            endcase
        end
    end

endmodule
